// File: rtl/updn_ctr_mod.sv
`default_nettype none
// ============================================================================
// Module      : updn_ctr_mod
// Description : Loadable up/down counter with programmable modulus, wrap or
//               saturate boundary mode and a registered boundary-event pulse.
//               Optional registered match output under UPDN_CTR_MATCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module updn_ctr_mod #(
   parameter int unsigned     WIDTH    = 3,
   parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
   parameter bit              SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             cen,
   input  logic             up_dn,
   input  logic [WIDTH-1:0] data,
`ifdef UPDN_CTR_MATCH_EN
   input  logic [WIDTH-1:0] match_val,
   output logic             match,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tercnt,
   output logic             bnd
);

   localparam longint unsigned c_range_top = (64'd1 << WIDTH) - 64'd1;

   generate
      if (WIDTH < 1 || WIDTH > 32 || MAX_VAL < 64'd1 || MAX_VAL > c_range_top) begin : g_bad_param
         $fatal(1, "updn_ctr_mod: WIDTH must be 1..32 and MAX_VAL 1..2**WIDTH-1");
      end
   endgenerate

   // Modulus held in counter width so every compare stays WIDTH bits wide.
   localparam logic [WIDTH-1:0] c_max = MAX_VAL[WIDTH-1:0];

   logic [WIDTH-1:0] count_q, count_d;
   logic             bnd_q, bnd_d;

   always_comb begin
      count_d = count_q;
      bnd_d   = 1'b0;
      if (!load) begin
         count_d = (data > c_max) ? c_max : data;
      end else if (cen) begin
         if (up_dn) begin
            if (count_q == c_max) begin
               count_d = SATURATE ? c_max : '0;
               bnd_d   = 1'b1;
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == '0) begin
               count_d = SATURATE ? '0 : c_max;
               bnd_d   = 1'b1;
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
         bnd_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         bnd_q   <= bnd_d;
      end
   end

   assign count  = count_q;
   assign bnd    = bnd_q;
   assign tercnt = up_dn ? (count_q == c_max) : (count_q == '0);

`ifdef UPDN_CTR_MATCH_EN
   // Compare against the next value so match rises together with count.
   logic match_q, match_d;

   always_comb begin
      match_d = (count_d == match_val);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match_d;
      end
   end

   assign match = match_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_updn_ctr_mod.sv
`default_nettype none
// ============================================================================
// Module      : tb_updn_ctr_mod
// Description : Self-checking bench for updn_ctr_mod, wrap and saturate copies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updn_ctr_mod;

   localparam int unsigned MAXV = 5;

   logic       clk;
   logic       reset;
   logic       load;
   logic       cen;
   logic       up_dn;
   logic [2:0] data;
   logic [2:0] count0, count1;
   logic       tercnt0, tercnt1, bnd0, bnd1;
`ifdef UPDN_CTR_MATCH_EN
   logic [2:0] match_val;
   logic       match0, match1;
`endif

   int checks   = 0;
   int failures = 0;
   bit run      = 0;

   updn_ctr_mod #(.WIDTH(3), .MAX_VAL(MAXV), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .load(load), .cen(cen), .up_dn(up_dn), .data(data),
`ifdef UPDN_CTR_MATCH_EN
      .match_val(match_val), .match(match0),
`endif
      .count(count0), .tercnt(tercnt0), .bnd(bnd0)
   );

   updn_ctr_mod #(.WIDTH(3), .MAX_VAL(MAXV), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .load(load), .cen(cen), .up_dn(up_dn), .data(data),
`ifdef UPDN_CTR_MATCH_EN
      .match_val(match_val), .match(match1),
`endif
      .count(count1), .tercnt(tercnt1), .bnd(bnd1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Model: modular arithmetic on plain integers.
   int unsigned mc0 = 0, mc1 = 0;
   bit          mb0 = 0, mb1 = 0;
   bit          mm0 = 0, mm1 = 0;

   function automatic int unsigned model_next(input int unsigned cur, input bit sat);
      if (!load) return (int'(data) > MAXV) ? MAXV : int'(data);
      if (!cen) return cur;
      if (up_dn) return (sat && cur == MAXV) ? MAXV : (cur + 1) % (MAXV + 1);
      return (sat && cur == 0) ? 0 : (cur + MAXV) % (MAXV + 1);
   endfunction

   function automatic bit model_bnd(input int unsigned cur);
      return load && cen && (up_dn ? (cur == MAXV) : (cur == 0));
   endfunction

   function automatic bit model_ter(input int unsigned cur);
      return up_dn ? (cur == MAXV) : (cur == 0);
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         mc0 <= 0; mc1 <= 0; mb0 <= 0; mb1 <= 0; mm0 <= 0; mm1 <= 0;
      end else begin
         mc0 <= model_next(mc0, 1'b0);
         mc1 <= model_next(mc1, 1'b1);
         mb0 <= model_bnd(mc0);
         mb1 <= model_bnd(mc1);
`ifdef UPDN_CTR_MATCH_EN
         mm0 <= (model_next(mc0, 1'b0) == int'(match_val));
         mm1 <= (model_next(mc1, 1'b1) == int'(match_val));
`endif
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("count_wrap", int'(count0), int'(mc0));
         chk("count_sat", int'(count1), int'(mc1));
         chk("bnd_wrap", int'(bnd0), int'(mb0));
         chk("bnd_sat", int'(bnd1), int'(mb1));
         chk("tercnt_wrap", int'(tercnt0), int'(model_ter(mc0)));
         chk("tercnt_sat", int'(tercnt1), int'(model_ter(mc1)));
`ifdef UPDN_CTR_MATCH_EN
         chk("match_wrap", int'(match0), int'(mm0));
         chk("match_sat", int'(match1), int'(mm1));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int exp_up_w[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
   int exp_up_wb[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
   int exp_up_s[8]  = '{1, 2, 3, 4, 5, 5, 5, 5};
   int exp_up_sb[8] = '{0, 0, 0, 0, 0, 1, 1, 1};
   int exp_dn_w[4]  = '{0, 5, 4, 3};
   int exp_dn_wb[4] = '{0, 1, 0, 0};
   int exp_dn_sb[4] = '{0, 1, 1, 1};

   initial begin
      reset = 1'b0; load = 1'b1; cen = 1'b0; up_dn = 1'b1; data = 3'd0;
`ifdef UPDN_CTR_MATCH_EN
      match_val = 3'd3;
`endif
      // Reset held for five edges.
      for (int i = 0; i < 5; i++) tick();
      run = 1'b1;
      chk("rst_count", int'(count0), 0);
      chk("rst_bnd", int'(bnd0), 0);
      chk("rst_tercnt_up", int'(tercnt0), 0);
`ifdef UPDN_CTR_MATCH_EN
      chk("rst_match", int'(match0), 0);
`endif
      up_dn = 1'b0;
      #1;
      chk("rst_tercnt_dn", int'(tercnt0), 1);

      // Load with clamp, then load beating a simultaneous count enable.
      reset = 1'b1; load = 1'b0; data = 3'd7; up_dn = 1'b1;
      tick();
      chk("load_clamp", int'(count0), 5);
      data = 3'd2;
      tick();
      chk("load_2", int'(count1), 2);
      data = 3'd4; cen = 1'b1;
      tick();
      chk("load_beats_cen", int'(count0), 4);

      // Wrap/saturate counting up from zero.
      data = 3'd0;
      tick();
      load = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("up_count_wrap", int'(count0), exp_up_w[i]);
         chk("up_bnd_wrap", int'(bnd0), exp_up_wb[i]);
         chk("up_count_sat", int'(count1), exp_up_s[i]);
         chk("up_bnd_sat", int'(bnd1), exp_up_sb[i]);
         if (i == 4) chk("up_tercnt_at_max", int'(tercnt0), 1);
      end

      // Saturate down from one.
      load = 1'b0; data = 3'd1; cen = 1'b0;
      tick();
      load = 1'b1; cen = 1'b1; up_dn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("dn_count_sat", int'(count1), 0);
         chk("dn_bnd_sat", int'(bnd1), exp_dn_sb[i]);
         chk("dn_tercnt_sat", int'(tercnt1), 1);
         chk("dn_count_wrap", int'(count0), exp_dn_w[i]);
         chk("dn_bnd_wrap", int'(bnd0), exp_dn_wb[i]);
      end

      // Reset mid-count overrides load and cen.
      load = 1'b0; data = 3'd3; cen = 1'b0; up_dn = 1'b1;
      tick();
      load = 1'b1; cen = 1'b1;
      tick();
      chk("pre_rst_count", int'(count0), 4);
      reset = 1'b0; load = 1'b0; data = 3'd2;
      tick();
      chk("mid_rst_count", int'(count0), 0);
      chk("mid_rst_bnd", int'(bnd1), 0);
      reset = 1'b1; load = 1'b1;
      tick();
      chk("post_rst_count", int'(count0), 1);

`ifdef UPDN_CTR_MATCH_EN
      load = 1'b0; data = 3'd0; cen = 1'b0;
      tick();
      load = 1'b1; cen = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("match_step", int'(match0), (i == 3) ? 1 : 0);
      end
      load = 1'b0; data = 3'd3; cen = 1'b0;
      tick();
      chk("match_load_count", int'(count0), 3);
      chk("match_load", int'(match0), 1);
`endif

      // A few hold cycles with the enable low.
      load = 1'b1; cen = 1'b0;
      tick();
      tick();
      run = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/updn_ctr_mod.md
Name: updn_ctr_mod

Overview:
Parametrised up/down counter with synchronous load, count enable and programmable modulus. It generalises the team's fixed 3-bit up/down counter to arbitrary width, non-power-of-two terminal value and a wrap/saturate mode. It adds a registered boundary-event pulse. It sits in control datapaths as a loadable event/position counter.

Parameters:
WIDTH, 3, counter and data width in bits (1..32).
MAX_VAL, 2**WIDTH-1, top of count range; count spans 0..MAX_VAL. Legal range is 1..2**WIDTH-1.
SATURATE, 0, boundary mode: 0 = wrap around, 1 = hold at boundary.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous active-low reset.
load  input  1  active-low synchronous load of data.
cen  input  1  active-high count enable.
up_dn  input  1  direction: 1 = up, 0 = down.
data  input  WIDTH  load value.
count  output  WIDTH  registered counter value.
tercnt  output  1  combinational terminal-count flag.
bnd  output  1  registered one-cycle boundary-event pulse.

Behaviour:
- All state is registered on posedge clk. Reset is synchronous and active-low: reset==0 at a rising edge sets count=0 and bnd=0.
- Priority at each rising edge is reset, then load, then cen, then hold:
  - reset==0: reset action above.
  - load==0: count <= min(data, MAX_VAL). Data above MAX_VAL clamps to MAX_VAL. bnd <= 0.
  - cen==1 and up_dn==1:
    - count<MAX_VAL: count+1, bnd <= 0.
    - count==MAX_VAL: count <= 0 (SATURATE=0) or stays MAX_VAL (SATURATE=1); bnd <= 1 in both cases.
  - cen==1 and up_dn==0:
    - count>0: count-1, bnd <= 0.
    - count==0: count <= MAX_VAL (SATURATE=0) or stays 0 (SATURATE=1); bnd <= 1.
  - cen==0: count holds, bnd <= 0.
- tercnt = (up_dn==1 && count==MAX_VAL) || (up_dn==0 && count==0). It is combinational from count and up_dn, with no gating by cen or load. After reset with up_dn=0, tercnt=1.
- Latency:
  - count changes one edge after a qualifying load or cen.
  - bnd asserts in the cycle after the edge that hit the boundary, for exactly one cycle per boundary step.
  - Consecutive saturated steps give bnd high continuously, once per step.
- A direction change takes effect at the next enabled edge. tercnt follows up_dn immediately.
- Load with cen=1 simultaneously: load wins and no count step occurs.
- Reset asserted mid-count overrides load and cen in that cycle. Counting resumes from 0 on the first edge with reset==1.
- Arithmetic is unsigned WIDTH-bit. Internal compares must not overflow when MAX_VAL==2**WIDTH-1.
- Illegal MAX_VAL (0 or above 2**WIDTH-1) is flagged by an elaboration-time check and stops elaboration.

Optional Feature:
Macro UPDN_CTR_MATCH_EN.
- Defined:
  - Adds input match_val [WIDTH-1:0] and output match (1 bit).
  - match is registered and equals (next count == match_val).
  - match therefore goes high in the same cycle count becomes equal to match_val, from either a load or a step.
  - match clears to 0 on reset.
- Undefined: the match_val and match ports and their logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset: WIDTH=3, reset=0 for 5 edges with load=1, cen=0 -> count=0, bnd=0; tercnt=0 with up_dn=1, tercnt=1 with up_dn=0.
- Load with clamp: WIDTH=3, MAX_VAL=5, load=0, data=7 -> count=5 next edge. Then data=2 -> count=2. Load and cen asserted together -> count=data, no step.
- Wrap up: WIDTH=3, MAX_VAL=5, SATURATE=0, cen=1, up_dn=1 from 0 for 8 edges -> count 1,2,3,4,5,0,1,2. bnd high only in the cycle count shows 0. tercnt high while count=5.
- Saturate down: SATURATE=1, load 1, cen=1, up_dn=0 for 4 edges -> count 0,0,0,0. bnd 0,1,1,1. tercnt=1 once count=0.
- Mid-run reset: counting up at count=4, reset=0 for one edge with cen=1, load=0 -> count=0, bnd=0. Next edge with reset=1 -> count=1.
- Match (UPDN_CTR_MATCH_EN defined): WIDTH=3, match_val=3, count up from 0 -> match high exactly while count=3. Then load data=3 -> match high the same cycle count=3.
